mux_pipe_sel: RTL
=================

Name: mux_pipe_sel

Overview:
- Parametrised N-channel, W-bit selector; successor to the fixed 10x8 two-stage group mux.
- Two registered stages:
  - Stage 1 picks one input within each group of GROUP channels.
  - Stage 2 picks among the group winners.
- Valid/ready handshake on input and output, full back-pressure.
- Out-of-range select falls back to channel 0 and is flagged.

Parameters:
- NCH, 10, number of input channels (2..64).
- W, 8, data width per channel.
- GROUP, 5, channels per stage-1 group (1..NCH); NGRP = ceil(NCH/GROUP).
- SELW, $clog2(NCH), select width (derived, local).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  NCH*W  channel k at bits [k*W +: W].
- in_sel  in  SELW  requested channel index.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat when in_valid && in_ready.
- out_data  out  W  selected data.
- out_sel  out  SELW  channel actually selected (0 when out of range).
- out_err  out  1  requested in_sel was >= NCH.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- err_cnt  out  16  saturating out-of-range count; only present with MUX_PIPE_SEL_ERRCNT_EN.

Behaviour:
- Reset (async, asserted immediately, released on clk): all valids 0; out_data, out_sel, out_err 0; err_cnt 0.
- Range check at accept: err = (in_sel >= NCH); eff_sel = err ? 0 : in_sel.
- Stage 1 register (v1):
  - grp = eff_sel / GROUP, idx = eff_sel % GROUP.
  - Stores each group's candidate in_data[(g*GROUP+idx)], plus grp, eff_sel, err.
  - A candidate index >= NCH in the last partial group gives zero. Unreachable after clamp; must still not produce X.
- Stage 2 register (v2): out_data = stored candidate[grp]; out_sel = eff_sel; out_err = err.
- Latency: 2 cycles accept-to-out_valid with no stall. Throughput 1 beat/cycle.
- Enables: en2 = !v2 || out_ready; en1 = !v1 || en2; in_ready = en1.
  - in_ready is combinational from out_ready; no other comb path.
- Stage 1 load: when en1, v1 <= in_valid && in_ready and data loads.
- Stage 2 load: when en2, v2 <= v1 and data loads from stage 1.
- Stall: v2 && !out_ready holds out_data, out_sel, out_err stable. Stage 1 holds if also full.
- Simultaneous accept and drain on the same cycle: allowed, no bubble.
- Data registers update only on beat transfer. out_data must not change while out_valid && !out_ready.
- in_data and in_sel are sampled only on an accepted beat; changes while in_ready=0 are ignored.
- Reset mid-operation drops all in-flight beats; no output for them.

Optional Feature:
- Macro: MUX_PIPE_SEL_ERRCNT_EN.
- Defined:
  - err_cnt port exists.
  - Increments by 1 when an output beat with out_err=1 transfers (out_valid && out_ready).
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package mux_pipe_pkg holds:
  - function clog2_f;
  - localparam-style helper function ngrp_f(nch, group);
  - typedef struct for stage-1 sideband {grp, eff_sel, err}, parametrised through the module.
- One sub-module, mux_pipe_grp_sel: combinational GROUP-input W-bit selector with zero default. Instantiated NGRP times for stage 1 and once (NGRP-wide) for stage 2.

Test Plan:
- Defaults, out_ready=1, in_sel=3 with channel k = 8'h10+k:
  - out_data=8'h13, out_sel=3, out_err=0 exactly 2 cycles after accept.
- in_sel=12 (>=NCH=10):
  - out_data = channel 0 (8'h10), out_sel=0, out_err=1.
  - With ERRCNT_EN, err_cnt=1 after the transfer.
- Back-to-back in_sel=0..9 with out_ready=0 after 1 cycle:
  - in_ready drops after two beats are held.
  - out_data stable at 8'h10.
  - On release all 10 beats arrive in order, no loss or duplication.
- NCH=7, GROUP=3 (partial last group), in_sel=6:
  - out_data = channel 6.
  - in_sel=7: out_err=1, channel 0.
- Assert rst for 1 cycle with 2 beats in flight and out_ready=0:
  - out_valid=0 immediately (async).
  - No stale beat emerges after release; in_ready=1 next cycle.
- ERRCNT_EN with err_cnt preloaded near saturation via 65535 error beats, then 3 more:
  - err_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/mux_pipe_sel_pkg.sv
// Shared helpers for the mux_pipe_sel selector: width and group-count functions.
package mux_pipe_pkg;

  // Never returns less than 1, so a one-wide select (GROUP=1, NGRP=1) still gets a real bit.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ngrp_f(input int nch, input int group);
    return (nch + group - 1) / group;
  endfunction

endpackage

// File: rtl/mux_pipe_grp_sel.sv
// Combinational N-input, W-bit selector; an index with no matching input yields zero.
module mux_pipe_grp_sel #(
  parameter int N  = 5,
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic [N*W-1:0] data_i,
  input  logic [SW-1:0]  sel_i,
  output logic [W-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SW'(k)) data_o = data_i[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_pipe_sel.sv
// Two-stage pipelined N-channel selector with valid/ready on both sides.
// Optional saturating error counter on err_cnt when MUX_PIPE_SEL_ERRCNT_EN is defined.
module mux_pipe_sel
  import mux_pipe_pkg::*;
#(
  parameter  int NCH   = 10,
  parameter  int W     = 8,
  parameter  int GROUP = 5,
  localparam int SELW  = clog2_f(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [SELW-1:0]   in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MUX_PIPE_SEL_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int NGRP = ngrp_f(NCH, GROUP);
  localparam int GSW  = clog2_f(GROUP);
  localparam int NGW  = clog2_f(NGRP);

  typedef struct packed {
    logic [NGW-1:0]  grp;
    logic [SELW-1:0] eff_sel;
    logic            err;
  } s1_side_t;

  logic                   en1, en2;
  logic                   v1_q, v2_q;
  logic [NGRP*GROUP*W-1:0] in_pad;
  logic [GSW-1:0]         idx_d;
  s1_side_t               side_d, side_q;
  logic [NGRP*W-1:0]      cand_d, cand_q;
  logic [W-1:0]           s2_data_d;
  logic [W-1:0]           out_data_q;
  logic [SELW-1:0]        out_sel_q;
  logic                   out_err_q;

  assign en2      = !v2_q || out_ready;
  assign en1      = !v1_q || en2;
  assign in_ready = en1;

  always_comb begin
    side_d.err     = ({1'b0, in_sel} >= (SELW+1)'(NCH));
    side_d.eff_sel = side_d.err ? '0 : in_sel;
    side_d.grp     = NGW'(side_d.eff_sel / GROUP);
    idx_d          = GSW'(side_d.eff_sel % GROUP);
  end

  // Channels past NCH in a partial last group read as zero rather than X.
  always_comb begin
    in_pad              = '0;
    in_pad[NCH*W-1:0]   = in_data;
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_s1
    mux_pipe_grp_sel #(.N(GROUP), .W(W), .SW(GSW)) u_s1_sel (
      .data_i (in_pad[g*GROUP*W +: GROUP*W]),
      .sel_i  (idx_d),
      .data_o (cand_d[g*W +: W])
    );
  end

  mux_pipe_grp_sel #(.N(NGRP), .W(W), .SW(NGW)) u_s2_sel (
    .data_i (cand_q),
    .sel_i  (side_q.grp),
    .data_o (s2_data_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      cand_q <= '0;
      side_q <= '0;
    end else if (en1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        cand_q <= cand_d;
        side_q <= side_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q       <= 1'b0;
      out_data_q <= '0;
      out_sel_q  <= '0;
      out_err_q  <= 1'b0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        out_data_q <= s2_data_d;
        out_sel_q  <= side_q.eff_sel;
        out_err_q  <= side_q.err;
      end
    end
  end

  assign out_valid = v2_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_err   = out_err_q;

`ifdef MUX_PIPE_SEL_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (v2_q && out_ready && out_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
